store_bus_writer: RTL

Store-side data-bus master for the single-cycle RV32I core: the write-direction counterpart of the load extraction in the register-file write-back path. Takes an SB/SH/SW request from the core (effective address from the ALU, rs2 data), converts it into word-aligned bus writes with byte enables, and stalls the core until every write is granted. Misaligned SH/SW that cross a word boundary are split into two aligned bus writes.

---
 rtl/store_bus_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/store_bus_writer.sv
// Store-side data-bus master for the single-cycle RV32I core.
// Converts SB/SH/SW requests into word-aligned bus writes with byte enables,
// splitting word-crossing stores into two writes, and stalls the core until done.

package store_bus_writer_pkg;
   // Mnemonic codes this block recognises; every other code is an illegal store
   localparam logic [5:0] MN_SB = 6'd20;
   localparam logic [5:0] MN_SH = 6'd21;
   localparam logic [5:0] MN_SW = 6'd22;
endpackage

module store_bus_writer
   import store_bus_writer_pkg::*;
#(
   parameter bit MISALIGNED_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   input  logic [5:0]  mnemonic,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_stall,
   output logic        st_done,
   output logic        st_err,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wrdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt
);

   typedef enum logic [1:0] {
      IDLE,
      REQ1,
      REQ2,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wrdata_q, bus_wrdata_d;
   logic [31:0] data_hi_q, data_hi_d;
   logic [3:0]  be_lo_q, be_lo_d;
   logic [3:0]  be_hi_q, be_hi_d;
   logic        split_q, split_d;
   logic        err_q, err_d;

   logic [1:0]  off;
   logic [3:0]  size_mask;
   logic        legal;
   logic [31:0] data_masked;
   logic [7:0]  be8;
   logic [63:0] data64;
   logic        split_req;
   logic        reject;

   // Decode the live request into lane-positioned enables and data; the data is
   // trimmed to the store size first so lanes outside the enables stay zero
   always_comb begin
      off       = st_addr[1:0];
      legal     = 1'b1;
      size_mask = 4'b0000;
      case (mnemonic)
         MN_SB:   size_mask = 4'b0001;
         MN_SH:   size_mask = 4'b0011;
         MN_SW:   size_mask = 4'b1111;
         default: legal     = 1'b0;
      endcase
      data_masked = st_data & {{8{size_mask[3]}}, {8{size_mask[2]}},
                               {8{size_mask[1]}}, {8{size_mask[0]}}};
      be8       = {4'b0000, size_mask} << off;
      data64    = {32'b0, data_masked} << {off, 3'b000};
      split_req = |be8[7:4];
      reject    = !legal || (split_req && (MISALIGNED_SPLIT == 1'b0));
   end

   // State and captured-request registers; reset abandons any transaction at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bus_addr_q   <= 32'h0;
         bus_wrdata_q <= 32'h0;
         data_hi_q    <= 32'h0;
         be_lo_q      <= 4'h0;
         be_hi_q      <= 4'h0;
         split_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_addr_q   <= bus_addr_d;
         bus_wrdata_q <= bus_wrdata_d;
         data_hi_q    <= data_hi_d;
         be_lo_q      <= be_lo_d;
         be_hi_q      <= be_hi_d;
         split_q      <= split_d;
         err_q        <= err_d;
      end
   end

   // Next-state sequencing: reject straight to DONE, otherwise one or two writes
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (st_valid) begin
               state_d = reject ? DONE : REQ1;
            end
         end
         REQ1: begin
            if (bus_gnt) begin
               state_d = split_q ? REQ2 : DONE;
            end
         end
         REQ2: begin
            if (bus_gnt) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the request once in IDLE and advance the bus word for the second half
   always_comb begin
      bus_addr_d   = bus_addr_q;
      bus_wrdata_d = bus_wrdata_q;
      data_hi_d    = data_hi_q;
      be_lo_d      = be_lo_q;
      be_hi_d      = be_hi_q;
      split_d      = split_q;
      err_d        = err_q;
      if ((state_q == IDLE) && st_valid) begin
         err_d = reject;
         if (!reject) begin
            bus_addr_d   = {st_addr[31:2], 2'b00};
            bus_wrdata_d = data64[31:0];
            data_hi_d    = data64[63:32];
            be_lo_d      = be8[3:0];
            be_hi_d      = be8[7:4];
            split_d      = split_req;
         end
      end else if ((state_q == REQ1) && bus_gnt && split_q) begin
         bus_addr_d   = bus_addr_q + 32'd4;
         bus_wrdata_d = data_hi_q;
      end
   end

   // Outputs decoded from state; the IDLE stall term is gated so reset forces it low
   always_comb begin
      bus_req  = (state_q == REQ1) || (state_q == REQ2);
      bus_be   = 4'b0000;
      if (state_q == REQ1) begin
         bus_be = be_lo_q;
      end else if (state_q == REQ2) begin
         bus_be = be_hi_q;
      end
      st_stall = ((state_q == IDLE) && st_valid && rst_n) ||
                 (state_q == REQ1) || (state_q == REQ2);
      st_done  = (state_q == DONE);
      st_err   = (state_q == DONE) && err_q;
   end

   assign bus_addr   = bus_addr_q;
   assign bus_wrdata = bus_wrdata_q;

endmodule
